// File: rtl/load_seq_if.sv
// rtl/load_seq_if.sv - request, memory, extender and write-back bundle for load_seq
`timescale 1ns/1ps
interface load_seq_if;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_addr;
  logic        req_word;
  logic        req_signed;
  logic [2:0]  req_rd;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic        mem_ack;
  logic [7:0]  ext_in;
  logic        ext_s;
  logic [15:0] ext_out;
  logic        wb_valid;
  logic        wb_ready;
  logic [15:0] wb_data;
  logic [2:0]  wb_rd;
  logic        wb_err;

  modport slave (
    input  req_valid, req_addr, req_word, req_signed, req_rd,
    input  mem_rdata, mem_ack, ext_out, wb_ready,
    output req_ready, mem_rd, mem_addr, ext_in, ext_s,
    output wb_valid, wb_data, wb_rd, wb_err
  );

  modport master (
    output req_valid, req_addr, req_word, req_signed, req_rd,
    output mem_rdata, mem_ack, ext_out, wb_ready,
    input  req_ready, mem_rd, mem_addr, ext_in, ext_s,
    input  wb_valid, wb_data, wb_rd, wb_err
  );
endinterface

// File: rtl/load_seq.sv
// rtl/load_seq.sv - byte/word load sequencer over an 8-bit memory port with timeout
`timescale 1ns/1ps
module load_seq #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic    clk,
  input  logic    reset,
  load_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RD_LO, RD_HI, WB} state_t;

  state_t      state;
  logic [15:0] addr;
  logic        word;
  logic        sgn;
  logic [2:0]  rd;
  logic [7:0]  lo_byte;
  logic [7:0]  wait_cnt;
  logic [15:0] wb_data_q;
  logic        wb_err_q;
  logic        timeout;

  // Last permitted un-acked cycle; an ack in that same cycle still wins.
  assign timeout = (wait_cnt == 8'(MAX_WAIT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      addr      <= 16'h0000;
      word      <= 1'b0;
      sgn       <= 1'b0;
      rd        <= 3'd0;
      lo_byte   <= 8'h00;
      wait_cnt  <= 8'd0;
      wb_data_q <= 16'h0000;
      wb_err_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            addr     <= bus.req_addr;
            word     <= bus.req_word;
            sgn      <= bus.req_signed;
            rd       <= bus.req_rd;
            wait_cnt <= 8'd0;
            state    <= RD_LO;
          end
        end
        RD_LO: begin
          if (bus.mem_ack) begin
            if (word) begin
              lo_byte  <= bus.mem_rdata;
              wait_cnt <= 8'd0;
              state    <= RD_HI;
            end else begin
              wb_data_q <= bus.ext_out;
              wb_err_q  <= 1'b0;
              state     <= WB;
            end
          end else if (timeout) begin
            wb_data_q <= 16'h0000;
            wb_err_q  <= 1'b1;
            state     <= WB;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        RD_HI: begin
          if (bus.mem_ack) begin
            wb_data_q <= {bus.mem_rdata, lo_byte};
            wb_err_q  <= 1'b0;
            state     <= WB;
          end else if (timeout) begin
            wb_data_q <= 16'h0000;
            wb_err_q  <= 1'b1;
            state     <= WB;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        WB: begin
          if (bus.wb_ready) begin
            wb_err_q <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.mem_rd    = (state == RD_LO) || (state == RD_HI);
  assign bus.wb_valid  = (state == WB);
  assign bus.mem_addr  = (state == RD_LO) ? addr :
                         (state == RD_HI) ? addr + 16'd1 : 16'h0000;
  assign bus.ext_in    = bus.mem_rdata;
  assign bus.ext_s     = sgn;
  assign bus.wb_data   = wb_data_q;
  assign bus.wb_rd     = rd;
  assign bus.wb_err    = wb_err_q;
endmodule

// File: tb/tb_load_seq.sv
// tb/tb_load_seq.sv - randomized self-checking bench for load_seq
`timescale 1ns/1ps
module tb_load_seq;
  localparam int MW = 4;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  load_seq_if bus();

  load_seq #(.MAX_WAIT(MW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Stand-in for the external szextend instance.
  assign bus.ext_out = bus.ext_s ? {{8{bus.ext_in[7]}}, bus.ext_in} : {8'h00, bus.ext_in};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_load(input logic [15:0] a, input logic w, input logic s, input logic [2:0] r,
                          input int dlo, input int dhi, input logic [7:0] blo, input logic [7:0] bhi,
                          input int bp, input logic hold_valid, input string tag);
    int cyc, phase, waited, rd_cycles, exp_lat, exp_rd;
    logic [15:0] exp_data, exp_addr;
    logic exp_err;
    if (dlo >= MW) begin
      exp_err = 1'b1; exp_data = 16'h0000; exp_rd = MW; exp_lat = MW + 1;
    end else if (!w) begin
      exp_err = 1'b0;
      exp_data = (s && blo >= 8'd128) ? 16'(blo) + 16'hFF00 : 16'(blo);
      exp_rd = dlo + 1; exp_lat = dlo + 2;
    end else if (dhi >= MW) begin
      exp_err = 1'b1; exp_data = 16'h0000; exp_rd = dlo + 1 + MW; exp_lat = dlo + 2 + MW;
    end else begin
      exp_err = 1'b0; exp_data = 16'(bhi) * 16'd256 + 16'(blo);
      exp_rd = dlo + dhi + 2; exp_lat = dlo + dhi + 3;
    end

    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++; $display("FAIL %s accept req_ready got %b want 1", tag, bus.req_ready);
    end
    bus.req_valid = 1'b1; bus.req_addr = a; bus.req_word = w; bus.req_signed = s; bus.req_rd = r;
    step();
    cyc = 1; phase = 0; waited = 0; rd_cycles = 0;
    while (bus.wb_valid !== 1'b1 && cyc < 60) begin
      checks++;
      if (bus.req_ready !== 1'b0) begin
        errors++; $display("FAIL %s busy req_ready got %b want 0 cyc %0d", tag, bus.req_ready, cyc);
      end
      if (bus.mem_rd === 1'b1) begin
        rd_cycles++;
        exp_addr = (phase == 0) ? a : a + 16'd1;
        checks++;
        if (bus.mem_addr !== exp_addr) begin
          errors++; $display("FAIL %s mem_addr got %h want %h", tag, bus.mem_addr, exp_addr);
        end
        checks++;
        if (bus.ext_s !== s) begin
          errors++; $display("FAIL %s ext_s got %b want %b", tag, bus.ext_s, s);
        end
        if (waited == ((phase == 0) ? dlo : dhi)) begin
          bus.mem_ack = 1'b1; bus.mem_rdata = (phase == 0) ? blo : bhi;
          phase++; waited = 0;
        end else begin
          bus.mem_ack = 1'b0; bus.mem_rdata = 8'($urandom); waited++;
        end
      end else begin
        bus.mem_ack = 1'b0;
      end
      // Requests arriving while busy must be ignored.
      bus.req_valid = 1'($urandom_range(0, 1)); bus.req_addr = 16'($urandom);
      step();
      cyc++;
    end
    bus.mem_ack = 1'b0;

    checks++;
    if (cyc != exp_lat) begin
      errors++; $display("FAIL %s latency got %0d want %0d", tag, cyc, exp_lat);
    end
    checks++;
    if (rd_cycles != exp_rd) begin
      errors++; $display("FAIL %s mem_rd cycles got %0d want %0d", tag, rd_cycles, exp_rd);
    end
    checks++;
    if (bus.wb_data !== exp_data || bus.wb_err !== exp_err || bus.wb_rd !== r) begin
      errors++; $display("FAIL %s result got data %h err %b rd %0d want data %h err %b rd %0d",
                         tag, bus.wb_data, bus.wb_err, bus.wb_rd, exp_data, exp_err, r);
    end

    for (int i = 0; i < bp; i++) begin
      bus.wb_ready = 1'b0;
      bus.req_valid = hold_valid ? 1'b1 : 1'($urandom_range(0, 1));
      bus.mem_ack = 1'($urandom_range(0, 1)); bus.mem_rdata = 8'($urandom);
      step();
      checks++;
      if (bus.wb_valid !== 1'b1 || bus.wb_data !== exp_data || bus.wb_err !== exp_err ||
          bus.wb_rd !== r || bus.req_ready !== 1'b0 || bus.mem_rd !== 1'b0 || bus.mem_addr !== 16'h0000) begin
        errors++; $display("FAIL %s hold valid %b data %h err %b rd %0d rdy %b mem_rd %b want 1 %h %b %0d 0 0",
                           tag, bus.wb_valid, bus.wb_data, bus.wb_err, bus.wb_rd, bus.req_ready, bus.mem_rd,
                           exp_data, exp_err, r);
      end
    end
    bus.wb_ready = 1'b1;
    bus.req_valid = hold_valid;
    step();
    bus.wb_ready = 1'b0; bus.mem_ack = 1'b0;
    checks++;
    if (bus.req_ready !== 1'b1 || bus.wb_valid !== 1'b0 || bus.wb_err !== 1'b0) begin
      errors++; $display("FAIL %s release rdy %b valid %b err %b want 1 0 0",
                         tag, bus.req_ready, bus.wb_valid, bus.wb_err);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.req_valid = 1'b0; bus.req_addr = 16'h0; bus.req_word = 1'b0; bus.req_signed = 1'b0; bus.req_rd = 3'd0;
    bus.mem_rdata = 8'h0; bus.mem_ack = 1'b0; bus.wb_ready = 1'b0;
    step(); step();
    reset = 1'b0;
    checks++;
    if (bus.req_ready !== 1'b1 || bus.mem_rd !== 1'b0 || bus.mem_addr !== 16'h0 || bus.wb_valid !== 1'b0 ||
        bus.wb_data !== 16'h0 || bus.wb_rd !== 3'd0 || bus.wb_err !== 1'b0 || bus.ext_s !== 1'b0) begin
      errors++; $display("FAIL reset rdy %b mem_rd %b addr %h valid %b data %h rd %0d err %b ext_s %b want 1 0 0 0 0 0 0 0",
                         bus.req_ready, bus.mem_rd, bus.mem_addr, bus.wb_valid, bus.wb_data, bus.wb_rd,
                         bus.wb_err, bus.ext_s);
    end
  endtask

  task automatic test_byte();
    run_load(16'h0010, 1'b0, 1'b0, 3'd1, 0, 0, 8'h89, 8'h00, 0, 1'b0, "byte_unsigned");
    run_load(16'h0020, 1'b0, 1'b1, 3'd2, 0, 0, 8'h89, 8'h00, 0, 1'b0, "byte_signed_neg");
    run_load(16'h0021, 1'b0, 1'b1, 3'd3, 2, 0, 8'h09, 8'h00, 0, 1'b0, "byte_signed_pos_wait");
  endtask

  task automatic test_word();
    run_load(16'hFFFF, 1'b1, 1'b1, 3'd5, 0, 0, 8'h34, 8'h12, 0, 1'b0, "word_wrap");
    run_load(16'h8000, 1'b1, 1'b0, 3'd6, 1, 2, 8'hF0, 8'h9A, 0, 1'b0, "word_wait");
  endtask

  task automatic test_timeout();
    run_load(16'h0100, 1'b0, 1'b0, 3'd4, 100, 0, 8'h55, 8'h00, 0, 1'b0, "timeout_lo");
    run_load(16'h0101, 1'b0, 1'b1, 3'd4, MW - 1, 0, 8'hC3, 8'h00, 0, 1'b0, "ack_last_cycle");
    run_load(16'h0200, 1'b1, 1'b0, 3'd7, 1, 100, 8'h11, 8'h22, 0, 1'b0, "timeout_hi");
    run_load(16'h0202, 1'b1, 1'b0, 3'd0, MW - 1, MW - 1, 8'hAB, 8'hCD, 0, 1'b0, "word_ack_last");
  endtask

  task automatic test_back_to_back();
    run_load(16'h3000, 1'b0, 1'b0, 3'd2, 0, 0, 8'h7E, 8'h00, 3, 1'b1, "backpressure");
    run_load(16'h3001, 1'b1, 1'b0, 3'd3, 0, 0, 8'h5A, 8'hA5, 0, 1'b0, "pending_accept");
  endtask

  task automatic test_reset_mid();
    bit seen;
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++; $display("FAIL rst_mid accept req_ready got %b want 1", bus.req_ready);
    end
    bus.req_valid = 1'b1; bus.req_addr = 16'h4000; bus.req_word = 1'b1; bus.req_signed = 1'b1; bus.req_rd = 3'd6;
    step();
    bus.req_valid = 1'b0; bus.mem_ack = 1'b1; bus.mem_rdata = 8'h55;
    step();
    checks++;
    if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 16'h4001) begin
      errors++; $display("FAIL rst_mid rd_hi mem_rd %b addr %h want 1 4001", bus.mem_rd, bus.mem_addr);
    end
    reset = 1'b1; bus.mem_ack = 1'b1; bus.mem_rdata = 8'h66;
    step();
    reset = 1'b0;
    checks++;
    if (bus.mem_rd !== 1'b0 || bus.wb_valid !== 1'b0 || bus.req_ready !== 1'b1 || bus.wb_data !== 16'h0 ||
        bus.ext_s !== 1'b0 || bus.mem_addr !== 16'h0 || bus.wb_rd !== 3'd0) begin
      errors++; $display("FAIL rst_mid after mem_rd %b valid %b rdy %b data %h ext_s %b addr %h rd %0d want 0 0 1 0 0 0 0",
                         bus.mem_rd, bus.wb_valid, bus.req_ready, bus.wb_data, bus.ext_s, bus.mem_addr, bus.wb_rd);
    end
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.mem_ack = 1'b1; bus.mem_rdata = 8'($urandom);
      step();
      if (bus.wb_valid !== 1'b0 || bus.mem_rd !== 1'b0) seen = 1'b1;
    end
    bus.mem_ack = 1'b0;
    checks++;
    if (seen) begin
      errors++; $display("FAIL rst_mid late_ack activity got 1 want 0");
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 25; n++) begin
      run_load(16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom),
               $urandom_range(0, MW + 1), $urandom_range(0, MW + 1), 8'($urandom), 8'($urandom),
               $urandom_range(0, 2), 1'($urandom_range(0, 1)), $sformatf("random_%0d", n));
    end
    bus.req_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_byte();
    test_word();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
